cpu_step_controller: RTL

- Sequences the board computer's execution by issuing one-cycle `cpu_step` enable pulses on the 50 MHz domain, instead of gating the CPU clock.
- Modes: manual single-step from a debounced pushbutton, free-run on a slow tick, and halt on a PC breakpoint.
- Owns the CPU synchronous reset sequencing and the executed-cycle counter that the hex displays show.
- Sits between the board inputs (KEY/SW, `clk_div` tick) and the `computer` instance.

---
 rtl/cpu_step_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cpu_step_controller.sv
// Step-enable sequencer for the board computer: reset pulses, manual step, free-run and PC breakpoint.
// Optional per-run step budget is compiled in with `define CPU_STEP_BUDGET_EN.
module cpu_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned COUNT_WIDTH     = 16,
  parameter int unsigned RESET_STEPS     = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run_mode,
  input  logic                   step_button,
  input  logic                   tick,
  input  logic [31:0]            pc,
  input  logic                   bp_enable,
  input  logic [31:0]            bp_addr,
`ifdef CPU_STEP_BUDGET_EN
  input  logic [15:0]            step_budget,
`endif
  output logic                   cpu_step,
  output logic                   cpu_reset,
  output logic                   halted,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RST_W = $clog2(RESET_STEPS + 2);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'b00,
    S_IDLE       = 2'b01,
    S_RUN        = 2'b10,
    S_HALT       = 2'b11
  } fsm_t;

  fsm_t             fsm_q;
  logic [1:0]       sync_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_level;
  logic             step_event;
  logic             skip_bp;
  logic [RST_W-1:0] rst_cnt;
  logic             bp_hit_c;
  logic             budget_hit_c;

  assign state    = fsm_q;
  assign bp_hit_c = bp_enable && (pc == bp_addr) && !skip_bp;

  // Button path: a change of the synchronised level is accepted only after it persists.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= 2'b00;
      deb_cnt    <= '0;
      deb_level  <= 1'b0;
      step_event <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], step_button};
      step_event <= 1'b0;
      if (sync_q[1] == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_cnt    <= '0;
        deb_level  <= sync_q[1];
        step_event <= sync_q[1];
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

`ifdef CPU_STEP_BUDGET_EN
  logic [15:0] run_cnt;

  assign budget_hit_c = (step_budget != 16'd0) && (run_cnt == step_budget);

  // Counts pulses issued in the current RUN visit; held at zero outside RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_cnt <= 16'd0;
    end else if (fsm_q != S_RUN) begin
      run_cnt <= 16'd0;
    end else if (run_mode && tick && !bp_hit_c && !budget_hit_c) begin
      run_cnt <= run_cnt + 16'd1;
    end
  end
`else
  assign budget_hit_c = 1'b0;
`endif

  // Mode sequencer; every output is a flop updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= S_RESET_HOLD;
      cpu_step    <= 1'b0;
      cpu_reset   <= 1'b1;
      halted      <= 1'b0;
      cycle_count <= '0;
      skip_bp     <= 1'b0;
      rst_cnt     <= '0;
    end else begin
      cpu_step <= 1'b0;
      case (fsm_q)
        S_RESET_HOLD: begin
          if (rst_cnt < RST_W'(RESET_STEPS)) begin
            cpu_step <= 1'b1;
            rst_cnt  <= rst_cnt + RST_W'(1);
          end else begin
            cpu_reset <= 1'b0;
            fsm_q     <= run_mode ? S_RUN : S_IDLE;
          end
        end
        S_IDLE: begin
          if (run_mode) begin
            fsm_q   <= S_RUN;
            skip_bp <= 1'b1;
          end else if (step_event) begin
            cpu_step    <= 1'b1;
            cycle_count <= cycle_count + COUNT_WIDTH'(1);
          end
        end
        S_RUN: begin
          if (!run_mode) begin
            fsm_q <= S_IDLE;
          end else if (tick) begin
            if (bp_hit_c || budget_hit_c) begin
              fsm_q  <= S_HALT;
              halted <= 1'b1;
            end else begin
              cpu_step    <= 1'b1;
              cycle_count <= cycle_count + COUNT_WIDTH'(1);
              skip_bp     <= 1'b0;
            end
          end
        end
        S_HALT: begin
          if (!run_mode) begin
            fsm_q  <= S_IDLE;
            halted <= 1'b0;
          end else if (step_event) begin
            cpu_step    <= 1'b1;
            cycle_count <= cycle_count + COUNT_WIDTH'(1);
          end
        end
        default: fsm_q <= S_RESET_HOLD;
      endcase
    end
  end

endmodule
